de_ibyte_queue: RTL and testbench
=================================

Name: de_ibyte_queue

Overview:
- Decode-side consumer of the fetch bundle. Receives 128-bit fetch lines (f_instr with valid/load qualifiers) and buffers up to 32 bytes.
- Presents a byte-aligned 16-byte window plus its EIP to the decoder, which returns the decoded instruction length to retire bytes.
- Returns backpressure (ld_fetch) and the consumed-length EIP update to fetch. Flushed on redirect (jump/branch resolution).

Parameters:
- QBYTES, 32, buffer capacity in bytes; must be 2×LBYTES.
- LBYTES, 16, fetch line width in bytes; f_instr width = 8×LBYTES.
- MAXLEN, 15, largest legal instruction length in bytes.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- clr  in  1  asynchronous active-low reset.
- f_instr  in  128  fetch line; byte k = bits [8k+7:8k], byte 0 lowest address.
- f_vin  in  1  line valid (fetch's de_vin).
- f_ld  in  1  fetch offers line this cycle (fetch's ld_de).
- ld_fetch  out  1  queue can accept a line this cycle (free bytes ≥ LBYTES).
- de_window  out  128  16 bytes starting at head; bytes at index ≥ count read 0.
- de_eip  out  32  EIP of window byte 0.
- de_count  out  6  valid bytes in queue, 0..32.
- de_valid  out  1  count ≥ LBYTES, or count ≥ de_len with de_len ≠ 0.
- de_len  in  4  decoder-computed length of instruction at head, 1..15.
- de_take  in  1  decoder retires de_len bytes this cycle.
- flush  in  1  redirect; discard all buffered bytes.
- flush_eip  in  32  new head EIP on flush.
- err_len  out  1  sticky: de_take with de_len=0 or de_len>count.

Behaviour:
- Reset (clr=0, async): count=0, head EIP=0, buffer bytes=0, err_len=0. Outputs: ld_fetch=1, de_valid=0, de_window=0, de_eip=0, de_count=0.
- Storage: QBYTES-byte array kept head-aligned. Byte 0 is always the head, so de_window = bytes[0..15]. Window output is combinational from registers (0-cycle latency).
- Accept: acc = f_ld & f_vin & ld_fetch. ld_fetch = (count ≤ QBYTES−LBYTES), combinational from registered count only, never from f_ld.
- Retire: ret = de_take & de_valid & (1 ≤ de_len ≤ count). Otherwise set err_len, retire nothing, and leave state unchanged.
- Next state, same edge:
  - shift buffer left by L = ret ? de_len : 0;
  - if acc, write the line at byte positions [count−L .. count−L+15];
  - count' = count − L + (acc ? 16 : 0);
  - head EIP' = EIP + L (32-bit wrap, mod 2^32).
- Simultaneous accept and retire at count=16: L bytes drop and the new line lands at 16−L. Max count stays ≤ 32.
- Full (count > 16): ld_fetch=0, and any offered line is ignored (fetch re-presents it).
- Empty: de_valid=0, window all zero. de_take is ignored, with no err_len.
- Flush has priority over accept and retire on the same edge: count'=0, head EIP'=flush_eip, buffer cleared to 0. err_len is unaffected. The line offered in the flush cycle is dropped.
- Bytes beyond count are always held at 0. The window never exposes stale data.
- err_len clears only on reset.

Optional Feature:
- IBQ_PERF_EN defined: adds outputs perf_starve (32 bits) and perf_full (32 bits), both saturating counters and both cleared on reset.
  - perf_starve increments each cycle with de_valid=0 and flush=0.
  - perf_full increments each cycle with f_ld & f_vin & !ld_fetch.
- Undefined: ports absent, no counters, no added logic.

Decomposition:
- Package ibq_pkg holds:
  - constants: LBYTES=16, QBYTES=32, MAXLEN=15, CNT_W=6, LEN_W=4;
  - typedefs: byte_t (8b), line_t (128b), eip_t (32b).
- One sub-module, ibq_shift_insert: combinational left-shift by L (0..15) plus line insert at offset (0..31). It is the only wide mux; the top holds registers and control.

Test Plan:
- Reset then fill: clr low→high; offer line bytes 0x00..0x0F with f_vin=1, f_ld=1 → next cycle count=16, de_window=that line, de_eip=0, de_valid=1, ld_fetch=1.
- Retire and refill: count=16, flush to eip 0x1000, de_len=3, de_take=1, plus a new line 0x10..0x1F → count=29, window bytes 0x03..0x12, de_eip=0x1003.
- Full backpressure: count=29 → ld_fetch=0; the offered line is not stored; count stays 29; err_len=0.
- Flush priority: flush=1, flush_eip=0x8000 together with accept and de_take → count=0, de_eip=0x8000, de_valid=0, window=0.
- Illegal length: count=4, de_len=7, de_take=1 → err_len=1, count=4 and EIP unchanged. Then de_len=0 with de_take=1 → err_len stays 1.
- EIP wrap: flush_eip=0xFFFFFFFE, fill line, retire 4 → de_eip=0x00000002. Under IBQ_PERF_EN, 5 empty cycles → perf_starve=5.

Source files
------------

// File: rtl/ibq_pkg.sv
// Shared constants and types for the decode-side instruction byte queue.
package ibq_pkg;

  localparam int unsigned LBYTES = 16;
  localparam int unsigned QBYTES = 32;
  localparam int unsigned MAXLEN = 15;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned LEN_W  = 4;

  typedef logic [7:0]          byte_t;
  typedef logic [8*LBYTES-1:0] line_t;
  typedef logic [31:0]         eip_t;

endpackage

// File: rtl/ibq_shift_insert.sv
// Combinational datapath: drop shamt_i head bytes (zero fill at the tail), then
// overlay a fetch line starting at byte offset_i when ins_i is set.
module ibq_shift_insert
  import ibq_pkg::*;
(
  input  logic [QBYTES-1:0][7:0] bytes_i,
  input  logic [LEN_W-1:0]       shamt_i,
  input  line_t                  line_i,
  input  logic                   ins_i,
  input  logic [CNT_W-1:0]       offset_i,
  output logic [QBYTES-1:0][7:0] bytes_o
);

  logic [LBYTES-1:0][7:0] line_b;

  assign line_b = line_i;

  always_comb begin
    bytes_o = '0;
    for (int i = 0; i < QBYTES; i++) begin : g_byte
      logic [CNT_W-1:0] src;
      logic [CNT_W-1:0] rel;
      src = CNT_W'(i) + CNT_W'(shamt_i);
      rel = CNT_W'(i) - offset_i;
      if (src < CNT_W'(QBYTES)) begin
        bytes_o[i] = bytes_i[src[4:0]];
      end
      if (ins_i && (CNT_W'(i) >= offset_i) && (rel < CNT_W'(LBYTES))) begin
        bytes_o[i] = line_b[rel[3:0]];
      end
    end
  end

endmodule

// File: rtl/de_ibyte_queue.sv
// Head-aligned instruction byte queue between fetch and decode.
// Define IBQ_PERF_EN to add saturating starvation / fetch-stall counters.
module de_ibyte_queue
  import ibq_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  line_t            f_instr,
  input  logic             f_vin,
  input  logic             f_ld,
  output logic             ld_fetch,
  output line_t            de_window,
  output eip_t             de_eip,
  output logic [CNT_W-1:0] de_count,
  output logic             de_valid,
  input  logic [LEN_W-1:0] de_len,
  input  logic             de_take,
  input  logic             flush,
  input  eip_t             flush_eip,
  output logic             err_len
`ifdef IBQ_PERF_EN
  ,
  output logic [31:0]      perf_starve,
  output logic [31:0]      perf_full
`endif
);

  logic [QBYTES-1:0][7:0] buf_q, buf_d, buf_nxt;
  logic [CNT_W-1:0]       count_q, count_d;
  eip_t                   eip_q, eip_d;
  logic                   err_q, err_d;

  logic [CNT_W-1:0] len_ext, drop, offset;
  logic [LEN_W-1:0] shamt;
  logic             legal, acc, ret;

  always_comb begin
    ld_fetch = count_q <= CNT_W'(QBYTES - LBYTES);
    len_ext  = CNT_W'(de_len);
    legal    = (de_len != '0) && (len_ext <= count_q);
    de_valid = (count_q >= CNT_W'(LBYTES)) || legal;
    acc      = f_ld & f_vin & ld_fetch;
    ret      = de_take & de_valid & legal;
    shamt    = ret ? de_len : '0;
    drop     = ret ? len_ext : '0;
    offset   = count_q - drop;
  end

  ibq_shift_insert u_shift_insert (
    .bytes_i  (buf_q),
    .shamt_i  (shamt),
    .line_i   (f_instr),
    .ins_i    (acc),
    .offset_i (offset),
    .bytes_o  (buf_nxt)
  );

  always_comb begin
    buf_d   = buf_nxt;
    count_d = offset + (acc ? CNT_W'(LBYTES) : '0);
    eip_d   = eip_q + eip_t'(drop);
    // Taking from an empty queue is a harmless no-op, not a length error.
    err_d   = err_q | (de_take & (count_q != '0) & ~legal);
    if (flush) begin
      buf_d   = '0;
      count_d = '0;
      eip_d   = flush_eip;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      buf_q   <= '0;
      count_q <= '0;
      eip_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      eip_q   <= eip_d;
      err_q   <= err_d;
    end
  end

  assign de_window = buf_q[LBYTES-1:0];
  assign de_eip    = eip_q;
  assign de_count  = count_q;
  assign err_len   = err_q;

`ifdef IBQ_PERF_EN
  logic [31:0] starve_q, starve_d, full_q, full_d;

  always_comb begin
    starve_d = starve_q;
    full_d   = full_q;
    if (!de_valid && !flush && (starve_q != '1)) begin
      starve_d = starve_q + 32'd1;
    end
    if (f_ld && f_vin && !ld_fetch && (full_q != '1)) begin
      full_d = full_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      starve_q <= '0;
      full_q   <= '0;
    end else begin
      starve_q <= starve_d;
      full_q   <= full_d;
    end
  end

  assign perf_starve = starve_q;
  assign perf_full   = full_q;
`endif

endmodule

// File: tb/tb_de_ibyte_queue.sv
// Scoreboard bench for de_ibyte_queue: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_de_ibyte_queue;

  logic         clk;
  logic         clr;
  logic [127:0] f_instr;
  logic         f_vin, f_ld;
  logic         ld_fetch;
  logic [127:0] de_window;
  logic [31:0]  de_eip;
  logic [5:0]   de_count;
  logic         de_valid;
  logic [3:0]   de_len;
  logic         de_take;
  logic         flush;
  logic [31:0]  flush_eip;
  logic         err_len;
`ifdef IBQ_PERF_EN
  logic [31:0]  perf_starve, perf_full;
`endif

  de_ibyte_queue dut (
    .clk       (clk),
    .clr       (clr),
    .f_instr   (f_instr),
    .f_vin     (f_vin),
    .f_ld      (f_ld),
    .ld_fetch  (ld_fetch),
    .de_window (de_window),
    .de_eip    (de_eip),
    .de_count  (de_count),
    .de_valid  (de_valid),
    .de_len    (de_len),
    .de_take   (de_take),
    .flush     (flush),
    .flush_eip (flush_eip),
    .err_len   (err_len)
`ifdef IBQ_PERF_EN
    ,
    .perf_starve (perf_starve),
    .perf_full   (perf_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [5:0]   cnt;
    logic [31:0]  eip;
    logic [127:0] win;
    logic         vld;
    logic         ld;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [127:0] mkwin(input logic [7:0] start, input int n);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = start + 8'(k);
    return w;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.nm, "count", 128'(de_count), 128'(e.cnt));
        cmp(e.nm, "eip",   128'(de_eip),   128'(e.eip));
        cmp(e.nm, "win",   de_window,      e.win);
        cmp(e.nm, "valid", 128'(de_valid), 128'(e.vld));
        cmp(e.nm, "ld",    128'(ld_fetch), 128'(e.ld));
        cmp(e.nm, "err",   128'(err_len),  128'(e.err));
      end
    end
  end

  task automatic expect_st(input string nm, input logic [5:0] c, input logic [31:0] ip,
                           input logic [127:0] w, input logic v, input logic l,
                           input logic er);
    exp_t e;
    e.nm = nm; e.cnt = c; e.eip = ip; e.win = w; e.vld = v; e.ld = l; e.err = er;
    sb.push_back(e);
  endtask

  task automatic idle();
    f_instr = '0; f_vin = 0; f_ld = 0; de_len = 0; de_take = 0; flush = 0; flush_eip = 0;
  endtask

  // Clock the currently driven inputs, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1 idle();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [127:0] ln);
    f_instr = ln; f_vin = 1; f_ld = 1;
  endtask

  logic [127:0] l0, l1, l2;

  initial begin
    l0 = mkwin(8'h00, 16);
    l1 = mkwin(8'h10, 16);
    l2 = mkwin(8'h20, 16);
    idle();
    clr = 0;
    repeat (2) @(posedge clk);
    #1 expect_st("reset", 0, 0, '0, 0, 1, 0);
    settle();
    clr = 1;

    offer(l0); tick();
    expect_st("fill", 16, 0, l0, 1, 1, 0); settle();

    flush = 1; flush_eip = 32'h1000; tick();
    expect_st("flush1000", 0, 32'h1000, '0, 0, 1, 0); settle();

    offer(l0); tick();
    expect_st("refill", 16, 32'h1000, l0, 1, 1, 0); settle();

    offer(l1); de_len = 3; de_take = 1; tick();
    expect_st("ret3_acc", 29, 32'h1003, mkwin(8'h03, 16), 1, 0, 0); settle();

    offer(l2); tick();
    expect_st("full_bp", 29, 32'h1003, mkwin(8'h03, 16), 1, 0, 0); settle();

    offer(l2); de_len = 2; de_take = 1; flush = 1; flush_eip = 32'h8000; tick();
    expect_st("flush_pri", 0, 32'h8000, '0, 0, 1, 0); settle();

    offer(l0); tick();
    expect_st("fill8000", 16, 32'h8000, l0, 1, 1, 0); settle();

    de_len = 12; de_take = 1; tick();
    expect_st("ret12", 4, 32'h800C, mkwin(8'h0C, 4), 0, 1, 0); settle();

    de_len = 4;
    expect_st("valid_len_eq", 4, 32'h800C, mkwin(8'h0C, 4), 1, 1, 0); settle();
    de_len = 5;
    expect_st("valid_len_gt", 4, 32'h800C, mkwin(8'h0C, 4), 0, 1, 0); settle();
    idle();

    de_len = 7; de_take = 1; tick();
    expect_st("bad_len7", 4, 32'h800C, mkwin(8'h0C, 4), 0, 1, 1); settle();

    de_len = 0; de_take = 1; tick();
    expect_st("bad_len0", 4, 32'h800C, mkwin(8'h0C, 4), 0, 1, 1); settle();

    de_len = 4; de_take = 1; tick();
    expect_st("ret_all", 0, 32'h8010, '0, 0, 1, 1); settle();

    de_len = 3; de_take = 1; tick();
    expect_st("take_empty", 0, 32'h8010, '0, 0, 1, 1); settle();

    flush = 1; flush_eip = 32'hFFFF_FFFE; tick();
    offer(l1); tick();
    expect_st("fill_wrap", 16, 32'hFFFF_FFFE, l1, 1, 1, 1); settle();

    offer(l2); de_len = 4; de_take = 1; tick();
    expect_st("wrap_ret4", 28, 32'h0000_0002, mkwin(8'h14, 16), 1, 0, 1); settle();

`ifdef IBQ_PERF_EN
    begin
      logic [31:0] s0;
      flush = 1; flush_eip = 0; tick();
      settle();
      s0 = perf_starve;
      repeat (5) @(posedge clk);
      #1;
      cmp("perf", "starve5", 128'(perf_starve - s0), 128'(32'd5));
    end
`endif

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
